ahbl_wb_bridge: RTL and testbench
=================================

AHBL_WB_BRIDGE -- requirements
Module: ahbl_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 32 or 64, data width of both ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum Wishbone wait in cycles; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named HCLK and HRESETn.
REQ-005 HCLK  in  1  clock; all logic rising-edge.
REQ-006 HRESETn  in  1  async active-low reset.
REQ-007 HSEL, HADDR[ADDR_WIDTH], HTRANS[2], HWRITE, HSIZE[3], HBURST[3], HWDATA[DATA_WIDTH], HREADY  in  AHB-Lite slave inputs.
REQ-008 HRDATA[DATA_WIDTH], HREADYOUT, HRESP[1]  out  AHB-Lite slave outputs; HRESP 0=OKAY, 1=ERROR.
REQ-009 wb_cyc, wb_stb, wb_we, wb_adr[ADDR_WIDTH], wb_sel[DATA_WIDTH/8], wb_dat_w[DATA_WIDTH], wb_cti[3], wb_bte[2]  out  Wishbone B4 classic master.
REQ-010 wb_dat_r[DATA_WIDTH], wb_ack, wb_err  in  Wishbone responses.

Function
REQ-011 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; IDLE/BUSY or unselected transfers SHALL get a zero-wait OKAY.
REQ-012 On acceptance, HADDR, HWRITE, HSIZE and HBURST SHALL be registered, and wb_adr SHALL be HADDR with its low log2(DATA_WIDTH/8) bits cleared.
REQ-013 wb_sel SHALL cover the 2^HSIZE bytes starting at the HADDR byte offset (little-endian).
REQ-014 An HSIZE wider than the bus, or an HADDR misaligned to HSIZE, SHALL produce an ERROR response with no Wishbone cycle.
REQ-015 FSM states SHALL be IDLE, BUS, ERR1, ERR2.
REQ-016 Transitions: IDLE->BUS on a legal accept; IDLE->ERR1 on an illegal accept; BUS->IDLE on wb_ack; BUS->ERR1 on wb_err or timeout; ERR1->ERR2; ERR2->IDLE, or ->BUS/ERR1 if a new transfer is accepted in ERR2.
REQ-017 In BUS, wb_cyc=wb_stb=1, and wb_dat_w SHALL be HWDATA passed through (data phase is valid).
REQ-018 HREADYOUT SHALL be 0 in BUS and ERR1, and 1 in IDLE and ERR2.
REQ-019 On wb_ack in BUS, HRDATA SHALL be registered from wb_dat_r, and HREADYOUT SHALL be 1 with HRESP=OKAY the next cycle.
REQ-020 Latency: address phase in cycle N, stb in N+1, ack in cycle A>=N+1, HREADYOUT=1 in A+1.
REQ-021 A new address phase accepted in cycle A+1 SHALL go directly to BUS with no idle gap.
REQ-022 ERROR response: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; wb_cyc/wb_stb SHALL drop in the cycle after wb_err or timeout.
REQ-023 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle, and reaching TIMEOUT_CYCLES without ack/err SHALL be treated as wb_err.
REQ-024 wb_ack and wb_err asserted in the same cycle SHALL be treated as err.
REQ-025 Burst tagging: a beat counter SHALL load 4/8/16 from HBURST on a NONSEQ of a fixed-length burst and decrement on each completed SEQ or NONSEQ beat.
REQ-026 wb_cti SHALL be 3'b010 while the remaining count is >1, 3'b111 on the last beat, and 3'b000 for SINGLE/INCR.
REQ-027 wb_bte SHALL be 01/10/11 for WRAP4/8/16 and 00 otherwise.
REQ-028 A NONSEQ arriving mid-burst SHALL reload the beat counter (early burst termination).
REQ-029 An ERROR on any beat SHALL clear the beat counter; the master's subsequent IDLE/NONSEQ is handled normally.

Reset
REQ-030 While HRESETn=0: FSM=IDLE, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_sel=0, wb_cti=0, wb_bte=0, HRDATA=0, HRESP=0, beat and timeout counters=0.
REQ-031 HREADYOUT SHALL be 1 during reset, gated by HRESETn so it is never 1 before HRESETn is sampled.
REQ-032 Reset asserted mid-BUS SHALL drop wb_cyc/wb_stb asynchronously; no response SHALL be owed after reset.

Structure
REQ-033 Package ahbl_wb_pkg SHALL hold the HTRANS/HBURST/HRESP encodings, the CTI/BTE constants and the FSM state enum.
REQ-034 Byte-lane logic SHALL be the sub-module ahbl_wb_sel_gen (HADDR offset, HSIZE -> wb_sel, illegal flag), parametrised by DATA_WIDTH.

Verification
REQ-035 Word write 0x1000=0xDEADBEEF, DATA_WIDTH=32, ack after 3 cycles -> wb_sel=1111, wb_we=1, HREADYOUT low 3 cycles then high, HRESP=0.
REQ-036 Byte read at 0x1003, wb_dat_r=0xAABBCCDD -> wb_sel=1000, wb_adr=0x1000, HRDATA=0xAABBCCDD.
REQ-037 INCR4 read 0x2000..0x200C, ack each cycle -> wb_cti 010,010,010,111, wb_bte=00, no idle cycle between beats.
REQ-038 Halfword at 0x1001 -> no wb_cyc, HRESP=1 for two cycles with HREADYOUT 0 then 1.
REQ-039 TIMEOUT_CYCLES=8, slave never acks -> wb_cyc drops after 8 BUS cycles, two-cycle ERROR response.
REQ-040 HRESETn pulsed low during BUS -> wb_cyc=0 immediately; after release, a single write completes with OKAY.

Source files
------------

// File: rtl/ahbl_wb_pkg.sv
// Shared encodings for the AHB-Lite to Wishbone B4 bridge: bus codes, CTI/BTE tags,
// FSM states and burst decode helpers.
package ahbl_wb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, ERR1, ERR2} state_t;

    // Beat count of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   burst_len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] burst_bte(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4:  burst_bte = BTE_WRAP4;
            HBURST_WRAP8:  burst_bte = BTE_WRAP8;
            HBURST_WRAP16: burst_bte = BTE_WRAP16;
            default:       burst_bte = BTE_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/ahbl_wb_sel_gen.sv
// Byte-lane decoder: HADDR byte offset and HSIZE to a little-endian select mask,
// flagging sizes wider than the bus and addresses misaligned to the size.
module ahbl_wb_sel_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_offset,
    input  logic [2:0]                      i_size,
    output logic [DATA_WIDTH/8-1:0]         o_sel,
    output logic                            o_illegal
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);

    int w_nbytes;
    int w_off;

    always_comb begin
        w_nbytes  = 1 << i_size;
        w_off     = int'(i_offset);
        o_illegal = (int'(i_size) > OFF_W) || ((w_off & (w_nbytes - 1)) != 0);
        for (int b = 0; b < NB; b++) begin
            o_sel[b] = !o_illegal && (b >= w_off) && (b < w_off + w_nbytes);
        end
    end

endmodule

// File: rtl/ahbl_wb_bridge.sv
// AHB-Lite slave to Wishbone B4 classic master bridge: one outstanding transfer,
// two-cycle ERROR response, bus timeout and CTI/BTE burst tagging.
module ahbl_wb_bridge
    import ahbl_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic [2:0]              wb_cti,
    output logic [1:0]              wb_bte,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                r_state;
    logic                  r_cyc;
    logic                  r_we;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [NB-1:0]         r_sel;
    logic [2:0]            r_cti;
    logic [1:0]            r_bte;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic [4:0]            r_beats;
    logic [TMO_W-1:0]      r_tmo;

    logic                  w_accept;
    logic                  w_illegal;
    logic [NB-1:0]         w_sel;
    logic [4:0]            w_beats_cur;
    logic [2:0]            w_cti_cur;
    logic                  w_tmo_hit;
    logic                  w_bus_err;

    ahbl_wb_sel_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel_gen (
        .i_offset  (HADDR[OFF_W-1:0]),
        .i_size    (HSIZE),
        .o_sel     (w_sel),
        .o_illegal (w_illegal)
    );

    assign w_accept = HSEL & HREADY & HTRANS[1];

    // A NONSEQ always restarts the count, which also handles early burst termination.
    assign w_beats_cur = (HTRANS == HTRANS_NONSEQ) ? burst_len(HBURST) : r_beats;
    assign w_cti_cur   = (w_beats_cur > 5'd1)  ? CTI_INCR :
                         (w_beats_cur == 5'd1) ? CTI_EOB  : CTI_CLASSIC;

    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_bus_err = wb_err | w_tmo_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_adr       <= '0;
            r_sel       <= '0;
            r_cti       <= CTI_CLASSIC;
            r_bte       <= BTE_LINEAR;
            r_hrdata    <= '0;
            r_beats     <= '0;
            r_tmo       <= '0;
        end else begin
            case (r_state)
                IDLE, ERR2: begin
                    if (w_accept && w_illegal) begin
                        r_state     <= ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                        r_beats     <= '0;
                    end else if (w_accept) begin
                        r_state     <= BUS;
                        r_cyc       <= 1'b1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_OKAY;
                        r_we        <= HWRITE;
                        r_adr       <= {HADDR[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        r_sel       <= w_sel;
                        r_cti       <= w_cti_cur;
                        r_bte       <= burst_bte(HBURST);
                        r_beats     <= w_beats_cur;
                        r_tmo       <= '0;
                    end else begin
                        r_state     <= IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                BUS: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    // err wins over a simultaneous ack
                    if (w_bus_err) begin
                        r_state     <= ERR1;
                        r_cyc       <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                        r_beats     <= '0;
                    end else if (wb_ack) begin
                        r_state     <= IDLE;
                        r_cyc       <= 1'b0;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                        r_hrdata    <= wb_dat_r;
                        if (r_beats != 5'd0) begin
                            r_beats <= r_beats - 5'd1;
                        end
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cyc       <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HRDATA    = r_hrdata;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign wb_cyc    = r_cyc;
    assign wb_stb    = r_cyc;
    assign wb_we     = r_we;
    assign wb_adr    = r_adr;
    assign wb_sel    = r_sel;
    assign wb_cti    = r_cti;
    assign wb_bte    = r_bte;
    // Write data is taken live from the AHB data phase, which spans the BUS state.
    assign wb_dat_w  = HWDATA;

endmodule

// File: tb/tb_ahbl_wb_bridge.sv
// Directed bench for ahbl_wb_bridge: single transfers, bursts, errors, timeout and
// reset during a Wishbone cycle, with a single AHB slave so HREADY loops from HREADYOUT.
module tb_ahbl_wb_bridge;
    import ahbl_wb_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_w;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    ahbl_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_sel    (wb_sel),
        .wb_dat_w  (wb_dat_w),
        .wb_cti    (wb_cti),
        .wb_bte    (wb_bte),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err)
    );

    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [2:0] b, input logic [1:0] t);
        HSEL   = 1'b1;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
        HBURST = b;
        HTRANS = t;
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
    endtask

    task automatic test_reset();
        HRESETn  = 1'b0;
        drive_idle();
        HADDR    = '0;
        HWRITE   = 1'b0;
        HSIZE    = 3'd0;
        HBURST   = HBURST_SINGLE;
        HWDATA   = '0;
        wb_dat_r = '0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
            errors++; $display("FAIL reset_cyc_stb_we got %b exp 000", {wb_cyc, wb_stb, wb_we});
        end
        checks++;
        if (wb_adr !== 32'h0) begin
            errors++; $display("FAIL reset_adr got %h exp 0", wb_adr);
        end
        checks++;
        if (wb_sel !== 4'h0) begin
            errors++; $display("FAIL reset_sel got %b exp 0000", wb_sel);
        end
        checks++;
        if ({wb_cti, wb_bte} !== 5'b0) begin
            errors++; $display("FAIL reset_cti_bte got %b exp 00000", {wb_cti, wb_bte});
        end
        checks++;
        if (HRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_hrdata got %h exp 0", HRDATA);
        end
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++; $display("FAIL reset_ready_resp got %b exp 10", {HREADYOUT, HRESP});
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_write_word();
        int low;
        drive_addr(32'h1000, 1'b1, 3'd2, HBURST_SINGLE, HTRANS_NONSEQ);
        HWDATA = 32'hDEADBEEF;
        @(negedge HCLK);
        drive_idle();
        checks++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b111) begin
            errors++; $display("FAIL wr_cyc_stb_we got %b exp 111", {wb_cyc, wb_stb, wb_we});
        end
        checks++;
        if (wb_sel !== 4'b1111 || wb_adr !== 32'h1000) begin
            errors++; $display("FAIL wr_sel_adr got %b/%h exp 1111/00001000", wb_sel, wb_adr);
        end
        checks++;
        if (wb_dat_w !== 32'hDEADBEEF || wb_cti !== CTI_CLASSIC) begin
            errors++; $display("FAIL wr_dat_cti got %h/%b exp deadbeef/000", wb_dat_w, wb_cti);
        end
        low = 0;
        while (HREADYOUT === 1'b0 && low < 20) begin
            low++;
            wb_ack = (low == 3);
            @(negedge HCLK);
        end
        wb_ack = 1'b0;
        checks++;
        if (low != 3) begin
            errors++; $display("FAIL wr_wait_cycles got %0d exp 3", low);
        end
        checks++;
        if ({HREADYOUT, HRESP, wb_cyc} !== 3'b100) begin
            errors++; $display("FAIL wr_done got %b exp 100", {HREADYOUT, HRESP, wb_cyc});
        end
    endtask

    task automatic test_read_byte();
        drive_addr(32'h1003, 1'b0, 3'd0, HBURST_SINGLE, HTRANS_NONSEQ);
        @(negedge HCLK);
        drive_idle();
        checks++;
        if (wb_sel !== 4'b1000 || wb_adr !== 32'h1000 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_byte_lanes got sel %b adr %h we %b exp 1000 00001000 0",
                     wb_sel, wb_adr, wb_we);
        end
        wb_ack   = 1'b1;
        wb_dat_r = 32'hAABBCCDD;
        @(negedge HCLK);
        wb_ack = 1'b0;
        checks++;
        if (HRDATA !== 32'hAABBCCDD || {HREADYOUT, HRESP} !== 2'b10) begin
            errors++;
            $display("FAIL rd_byte_data got %h %b exp aabbccdd 10", HRDATA, {HREADYOUT, HRESP});
        end
    endtask

    task automatic test_incr4();
        logic [2:0] exp_cti [4];
        exp_cti = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};
        drive_addr(32'h2000, 1'b0, 3'd2, HBURST_INCR4, HTRANS_NONSEQ);
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            checks++;
            if (wb_stb !== 1'b1 || wb_adr !== 32'h2000 + 32'(4 * i)) begin
                errors++; $display("FAIL incr4_beat%0d_stb_adr got %b %h", i, wb_stb, wb_adr);
            end
            checks++;
            if (wb_cti !== exp_cti[i] || wb_bte !== BTE_LINEAR) begin
                errors++;
                $display("FAIL incr4_beat%0d_tag got %b/%b exp %b/00", i, wb_cti, wb_bte,
                         exp_cti[i]);
            end
            wb_ack   = 1'b1;
            wb_dat_r = 32'h11110000 + 32'(i);
            if (i < 3) drive_addr(32'h2004 + 32'(4 * i), 1'b0, 3'd2, HBURST_INCR4, HTRANS_SEQ);
            else drive_idle();
            @(negedge HCLK);
            wb_ack = 1'b0;
            checks++;
            if (HREADYOUT !== 1'b1 || HRDATA !== 32'h11110000 + 32'(i)) begin
                errors++; $display("FAIL incr4_beat%0d_done got %b %h", i, HREADYOUT, HRDATA);
            end
        end
    endtask

    task automatic test_wrap_early_term();
        logic [31:0] adr   [6];
        logic [1:0]  trans [6];
        logic [2:0]  burst [6];
        logic [2:0]  ecti  [6];
        logic [1:0]  ebte  [6];
        adr   = '{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h3200, 32'h3204};
        trans = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_NONSEQ, HTRANS_NONSEQ,
                  HTRANS_SEQ};
        burst = '{HBURST_WRAP4, HBURST_WRAP4, HBURST_WRAP4, HBURST_SINGLE, HBURST_WRAP8,
                  HBURST_WRAP8};
        ecti  = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_CLASSIC, CTI_INCR, CTI_INCR};
        ebte  = '{BTE_WRAP4, BTE_WRAP4, BTE_WRAP4, BTE_LINEAR, BTE_WRAP8, BTE_WRAP8};
        drive_addr(adr[0], 1'b0, 3'd2, burst[0], trans[0]);
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            checks++;
            if (wb_stb !== 1'b1 || wb_cti !== ecti[i] || wb_bte !== ebte[i]) begin
                errors++;
                $display("FAIL wrap_beat%0d got stb %b cti %b bte %b exp 1 %b %b", i, wb_stb,
                         wb_cti, wb_bte, ecti[i], ebte[i]);
            end
            wb_ack = 1'b1;
            if (i < 5) drive_addr(adr[i+1], 1'b0, 3'd2, burst[i+1], trans[i+1]);
            else drive_idle();
            @(negedge HCLK);
            wb_ack = 1'b0;
        end
    endtask

    task automatic test_err_in_burst();
        drive_addr(32'h5000, 1'b0, 3'd2, HBURST_INCR4, HTRANS_NONSEQ);
        @(negedge HCLK);
        wb_ack = 1'b1;
        drive_addr(32'h5004, 1'b0, 3'd2, HBURST_INCR4, HTRANS_SEQ);
        @(negedge HCLK);
        wb_ack = 1'b0;
        @(negedge HCLK);
        checks++;
        if (wb_stb !== 1'b1 || wb_cti !== CTI_INCR) begin
            errors++; $display("FAIL errb_beat1 got stb %b cti %b exp 1 010", wb_stb, wb_cti);
        end
        wb_ack = 1'b1;
        wb_err = 1'b1;
        @(negedge HCLK);
        wb_ack = 1'b0;
        wb_err = 1'b0;
        checks++;
        if ({HREADYOUT, HRESP, wb_cyc} !== 3'b010) begin
            errors++; $display("FAIL errb_err1 got %b exp 010", {HREADYOUT, HRESP, wb_cyc});
        end
        drive_addr(32'h5008, 1'b0, 3'd2, HBURST_INCR4, HTRANS_SEQ);
        @(negedge HCLK);
        checks++;
        if ({HREADYOUT, HRESP, wb_cyc} !== 3'b110) begin
            errors++; $display("FAIL errb_err2 got %b exp 110", {HREADYOUT, HRESP, wb_cyc});
        end
        @(negedge HCLK);
        drive_idle();
        checks++;
        if (wb_stb !== 1'b1 || wb_cti !== CTI_CLASSIC) begin
            errors++; $display("FAIL errb_after got stb %b cti %b exp 1 000", wb_stb, wb_cti);
        end
        wb_ack = 1'b1;
        @(negedge HCLK);
        wb_ack = 1'b0;
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++; $display("FAIL errb_recover got %b exp 10", {HREADYOUT, HRESP});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] a  [2];
        logic [2:0]  sz [2];
        a  = '{32'h1001, 32'h1000};
        sz = '{3'd1, 3'd3};
        for (int i = 0; i < 2; i++) begin
            drive_addr(a[i], 1'b1, sz[i], HBURST_SINGLE, HTRANS_NONSEQ);
            @(negedge HCLK);
            drive_idle();
            checks++;
            if ({HREADYOUT, HRESP, wb_cyc} !== 3'b010) begin
                errors++;
                $display("FAIL illegal%0d_err1 got %b exp 010", i, {HREADYOUT, HRESP, wb_cyc});
            end
            @(negedge HCLK);
            checks++;
            if ({HREADYOUT, HRESP, wb_cyc} !== 3'b110) begin
                errors++;
                $display("FAIL illegal%0d_err2 got %b exp 110", i, {HREADYOUT, HRESP, wb_cyc});
            end
            @(negedge HCLK);
            checks++;
            if ({HREADYOUT, HRESP} !== 2'b10) begin
                errors++; $display("FAIL illegal%0d_idle got %b exp 10", i, {HREADYOUT, HRESP});
            end
        end
    endtask

    task automatic test_timeout();
        int cyc_cnt;
        drive_addr(32'h4000, 1'b0, 3'd2, HBURST_SINGLE, HTRANS_NONSEQ);
        @(negedge HCLK);
        drive_idle();
        cyc_cnt = 0;
        while (wb_cyc === 1'b1 && cyc_cnt < 40) begin
            cyc_cnt++;
            @(negedge HCLK);
        end
        checks++;
        if (cyc_cnt != 8) begin
            errors++; $display("FAIL timeout_cycles got %0d exp 8", cyc_cnt);
        end
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b01) begin
            errors++; $display("FAIL timeout_err1 got %b exp 01", {HREADYOUT, HRESP});
        end
        @(negedge HCLK);
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b11) begin
            errors++; $display("FAIL timeout_err2 got %b exp 11", {HREADYOUT, HRESP});
        end
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid_bus();
        drive_addr(32'h6000, 1'b1, 3'd2, HBURST_SINGLE, HTRANS_NONSEQ);
        HWDATA = 32'h12345678;
        @(negedge HCLK);
        drive_idle();
        checks++;
        if (wb_cyc !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got cyc %b exp 1", wb_cyc);
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, HREADYOUT} !== 3'b001) begin
            errors++; $display("FAIL rstmid_async got %b exp 001", {wb_cyc, wb_stb, HREADYOUT});
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        drive_addr(32'h6004, 1'b1, 3'd2, HBURST_SINGLE, HTRANS_NONSEQ);
        HWDATA = 32'hCAFEF00D;
        @(negedge HCLK);
        drive_idle();
        checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== 32'h6004 || wb_dat_w !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rstmid_write got cyc %b adr %h dat %h", wb_cyc, wb_adr, wb_dat_w);
        end
        wb_ack = 1'b1;
        @(negedge HCLK);
        wb_ack = 1'b0;
        checks++;
        if ({HREADYOUT, HRESP, wb_cyc} !== 3'b100) begin
            errors++; $display("FAIL rstmid_done got %b exp 100", {HREADYOUT, HRESP, wb_cyc});
        end
    endtask

    initial begin
        test_reset();
        test_write_word();
        test_read_byte();
        test_incr4();
        test_wrap_early_term();
        test_err_in_burst();
        test_illegal();
        test_timeout();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
